instr_mem_bank_arbiter: RTL

- Parametrised successor to the three-CPU fixed bank decoder.
- Connects N_CPU instruction-fetch ports to N_BANK single-port synchronous instruction-memory banks.
- Decodes each fetch address to a bank and arbitrates per bank: round-robin or fixed priority.
- Returns read data one cycle after grant, with a valid strobe per CPU.
- Sits between the CPU fetch stages and the bank ROM/RAM instances in the multi-CPU top.

---
 rtl/instr_mem_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/instr_mem_bank_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/instr_mem_arb_pkg.sv
// Shared sizing helpers and the saturating address-to-bank decode used by the
// bank arbiter and its bench model.
package instr_mem_arb_pkg;

  function automatic int cpu_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Addresses at or beyond the last bank's base all land in the last bank.
  function automatic int addr_to_bank(input logic [63:0] addr, input int bank_words,
                                      input int n_bank);
    logic [63:0] sat_base;
    sat_base = 64'(n_bank - 1) * 64'(bank_words);
    if (addr >= sat_base) return n_bank - 1;
    return int'(addr >> $clog2(bank_words));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-bank arbiter: round-robin from an internal pointer, or fixed priority
// (lowest index) when RR_EN=0.
module rr_arbiter
  import instr_mem_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int RR_EN = 1,
  localparam int IW   = cpu_idx_w(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_c;
  logic          w_found;

  // Scan N candidates starting at the pointer, wrapping mod N.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_c       = '0;
    for (int k = 0; k < N; k++) begin
      if (RR_EN != 0) begin
        w_sum = {1'b0, r_ptr} + (IW+1)'(k);
        if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      end else begin
        w_sum = (IW+1)'(k);
      end
      w_c = w_sum[IW-1:0];
      if (!w_found && i_req[w_c]) begin
        w_found      = 1'b1;
        o_gnt[w_c]   = 1'b1;
        o_gnt_idx    = w_c;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ptr <= '0;
    else if (RR_EN != 0 && i_advance)
      r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
  end

endmodule

// File: rtl/instr_mem_bank_arbiter.sv
// N_CPU fetch ports onto N_BANK synchronous instruction banks: decode, per-bank
// arbitration, and a one-cycle registered return path.
module instr_mem_bank_arbiter
  import instr_mem_arb_pkg::*;
#(
  parameter int N_CPU      = 3,
  parameter int N_BANK     = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BANK_WORDS = 128,
  parameter int RR_EN      = 1,
  localparam int LW        = $clog2(BANK_WORDS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_CPU-1:0]                   i_cpu_req,
  input  logic [N_CPU-1:0][ADDR_W-1:0]       i_cpu_addr,
  output logic [N_CPU-1:0]                   o_cpu_gnt,
  output logic [N_CPU-1:0]                   o_cpu_rvalid,
  output logic [N_CPU-1:0][DATA_W-1:0]       o_cpu_rdata,
  output logic [N_BANK-1:0]                  o_mem_en,
  output logic [N_BANK-1:0][LW-1:0]          o_mem_addr,
  input  logic [N_BANK-1:0][DATA_W-1:0]      i_mem_rdata
);

  localparam int CW = cpu_idx_w(N_CPU);
  localparam int BW = bank_idx_w(N_BANK);

  logic [N_CPU-1:0][BW-1:0]  w_bank;
  logic [N_CPU-1:0][LW-1:0]  w_local;
  logic [N_BANK-1:0][N_CPU-1:0] w_breq;
  logic [N_BANK-1:0][N_CPU-1:0] w_bgnt;
  logic [N_BANK-1:0][CW-1:0]    w_bidx;
  logic [N_CPU-1:0]          r_gnt_q;
  logic [N_CPU-1:0][BW-1:0]  r_bank_q;

  always_comb begin
    for (int i = 0; i < N_CPU; i++) begin
      w_bank[i]  = BW'(addr_to_bank(64'(i_cpu_addr[i]), BANK_WORDS, N_BANK));
      w_local[i] = i_cpu_addr[i][LW-1:0];
    end
    for (int b = 0; b < N_BANK; b++)
      for (int i = 0; i < N_CPU; i++)
        w_breq[b][i] = i_cpu_req[i] && (w_bank[i] == BW'(b));
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    rr_arbiter #(.N(N_CPU), .RR_EN(RR_EN)) u_arb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (w_breq[b]),
      .i_advance (|w_bgnt[b]),
      .o_gnt     (w_bgnt[b]),
      .o_gnt_idx (w_bidx[b])
    );
  end

  // Each CPU decodes to exactly one bank, so OR-ing bank grants never collides.
  always_comb begin
    o_cpu_gnt = '0;
    for (int b = 0; b < N_BANK; b++) begin
      o_cpu_gnt     = o_cpu_gnt | w_bgnt[b];
      o_mem_en[b]   = |w_bgnt[b];
      o_mem_addr[b] = o_mem_en[b] ? w_local[w_bidx[b]] : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt_q  <= '0;
      r_bank_q <= '0;
    end else begin
      r_gnt_q  <= o_cpu_gnt;
      r_bank_q <= w_bank;
    end
  end

  always_comb begin
    o_cpu_rvalid = r_gnt_q;
    for (int i = 0; i < N_CPU; i++)
      o_cpu_rdata[i] = r_gnt_q[i] ? i_mem_rdata[r_bank_q[i]] : '0;
  end

endmodule
